spi_reg_frontend: RTL and testbench

SPI_REG_FRONTEND -- requirements
Module: spi_reg_frontend

---
 rtl/spi_reg_frontend.sv | 169 ++++++++++++++++
 tb/tb_spi_reg_frontend.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_frontend.sv
// SPI mode-0 slave front end for a register bank.
// Oversamples SCLK/CS_N/MOSI on SPI_CLK; device byte, register byte, data bytes.
module spi_reg_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic       SPI_CLK,
  input  logic       RST_N,
  input  logic       SCLK,
  input  logic       CS_N,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [6:0] spi_addr,
  output logic [7:0] address,
  output logic [7:0] data_in,
  output logic       read_strobe,
  output logic       write_strobe,
  input  logic [7:0] data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_REG, S_DATA, S_SKIP
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s, r_fill;
  logic r_sclk_d, r_cs_d, r_armed;
  logic w_sclk, w_cs, w_mosi;
  logic w_rise, w_fall, w_cs_fall, w_active, w_done, w_dev_ok;
  logic [7:0] w_byte;

  logic [2:0] r_bitcnt;
  logic [6:0] r_rx;
  logic [6:0] r_tx;
  logic       r_miso, r_rw, r_tx_arm, r_rd_req;
  logic [7:0] r_addr, r_data;
  logic       r_rd_stb, r_wr_stb;
  logic       w_oe;

  always_ff @(posedge SPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_fill   <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], SCLK};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], CS_N};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], MOSI};
      r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
      // only a CS_N fall seen on real samples after reset opens a frame
      if (r_fill[SYNC_STAGES-1] && w_cs)
        r_armed <= 1'b1;
    end
  end

  assign w_sclk    = r_sclk_s[SYNC_STAGES-1];
  assign w_cs      = r_cs_s[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d & ~w_cs;
  assign w_fall    = ~w_sclk & r_sclk_d & ~w_cs;
  assign w_cs_fall = ~w_cs & r_cs_d & r_armed;
  assign w_active  = (r_state == S_DEV) || (r_state == S_REG) ||
                     (r_state == S_DATA);
  assign w_done    = w_rise && (r_bitcnt == 3'd7) && w_active;
  assign w_byte    = {r_rx, w_mosi};
  assign w_dev_ok  = (w_byte[7:1] == spi_addr);

  always_ff @(posedge SPI_CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_cs) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_next = S_DEV;
        S_DEV:  if (w_done) w_next = w_dev_ok ? S_REG : S_SKIP;
        S_REG:  if (w_done) w_next = S_DATA;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_oe    = (r_state == S_DATA) && r_rw && !w_cs;
    MISO_OE = w_oe;
    MISO    = w_oe & r_miso;
  end

  always_ff @(posedge SPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_miso   <= 1'b0;
      r_rw     <= 1'b0;
      r_tx_arm <= 1'b0;
      r_rd_req <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
    end else begin
      r_rd_req <= 1'b0;
      r_rd_stb <= r_rd_req;
      r_wr_stb <= 1'b0;
      if (r_wr_stb && AUTO_INC)
        r_addr <= r_addr + 8'd1;
      if (r_state == S_IDLE) begin
        r_bitcnt <= '0;
      end else if (w_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_rx     <= w_byte[6:0];
      end
      if (w_done) begin
        case (r_state)
          S_DEV: if (w_dev_ok) r_rw <= w_byte[0];
          S_REG: begin
            r_addr   <= w_byte;
            r_rd_req <= r_rw;
          end
          S_DATA: begin
            if (r_rw) begin
              if (AUTO_INC) r_addr <= r_addr + 8'd1;
              r_rd_req <= 1'b1;
            end else begin
              r_data   <= w_byte;
              r_wr_stb <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (r_rd_stb)
        r_tx_arm <= 1'b1;
      if (r_state == S_IDLE) begin
        r_tx_arm <= 1'b0;
        r_miso   <= 1'b0;
      end else if (w_fall && r_state == S_DATA && r_rw) begin
        // first fall after a read request presents the fresh bank data
        if (r_tx_arm) begin
          r_tx     <= data_out[6:0];
          r_miso   <= data_out[7];
          r_tx_arm <= 1'b0;
        end else begin
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[5:0], 1'b0};
        end
      end
    end
  end

  assign address      = r_addr;
  assign data_in      = r_data;
  assign read_strobe  = r_rd_stb;
  assign write_strobe = r_wr_stb;

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Bench for spi_reg_frontend: bank model, strobe scoreboard, SPI master tasks.
module tb_spi_reg_frontend;

  logic       clk = 1'b0;
  logic       RST_N, SCLK, CS_N, MOSI;
  logic       MISO, MISO_OE;
  logic [6:0] spi_addr;
  logic [7:0] address, data_in, data_out;
  logic       read_strobe, write_strobe;

  always #5 clk = ~clk;

  spi_reg_frontend dut (
    .SPI_CLK(clk), .RST_N(RST_N), .SCLK(SCLK), .CS_N(CS_N),
    .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .spi_addr(spi_addr), .address(address), .data_in(data_in),
    .read_strobe(read_strobe), .write_strobe(write_strobe),
    .data_out(data_out)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_miso[$];
  logic [7:0] mem [256];
  int         checks = 0;
  int         failures = 0;
  logic       watch_skip = 1'b0;
  int         skip_viol = 0;
  logic       prev_ws = 1'b0, prev_rs = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'h5A;
    mem[7] = 8'hC3;
    mem[8] = 8'h5E;
    data_out = 8'h00;
  end

  always @(posedge clk) begin
    if (read_strobe) data_out <= mem[address];
    if (write_strobe) mem[address] <= data_in;
  end

  always @(negedge clk) begin
    if (RST_N) begin
      if (write_strobe) begin
        checks++;
        if (exp_wr.size() == 0 || prev_ws || read_strobe) begin
          failures++;
          $display("FAIL write_strobe unexpected addr=%h data=%h", address, data_in);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if (address !== e.a || data_in !== e.d) begin
            failures++;
            $display("FAIL write got %h=%h want %h=%h", address, data_in, e.a, e.d);
          end
        end
      end
      if (read_strobe) begin
        checks++;
        if (exp_rd.size() == 0 || prev_rs) begin
          failures++;
          $display("FAIL read_strobe unexpected addr=%h", address);
        end else begin
          logic [7:0] ea;
          ea = exp_rd.pop_front();
          if (address !== ea) begin
            failures++;
            $display("FAIL read addr got %h want %h", address, ea);
          end
        end
      end
      if (watch_skip && (MISO_OE !== 1'b0 || MISO !== 1'b0)) skip_viol++;
    end
    prev_ws = write_strobe;
    prev_rs = read_strobe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_start();
    CS_N = 1'b0;
    tick(8);
  endtask

  task automatic spi_stop();
    tick(8);
    CS_N = 1'b1;
    tick(16);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      tick(8);
      rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      tick(8);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame3(input logic [7:0] b0, b1, b2);
    logic [7:0] rx;
    spi_start();
    spi_xfer(b0, 8, rx);
    spi_xfer(b1, 8, rx);
    spi_xfer(b2, 8, rx);
    spi_stop();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CS_N = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    spi_addr = 7'h12;
    tick(3);
    checks++;
    if (address !== 8'h00 || data_in !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs addr=%h data=%h want 00/00", address, data_in);
    end
    checks++;
    if (read_strobe !== 1'b0 || write_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes rs=%b ws=%b want 0/0", read_strobe, write_strobe);
    end
    checks++;
    if (MISO !== 1'b0 || MISO_OE !== 1'b0) begin
      failures++;
      $display("FAIL reset_miso miso=%b oe=%b want 0/0", MISO, MISO_OE);
    end
    RST_N = 1'b1;
    tick(10);
  endtask

  task automatic test_write();
    exp_wr.push_back({8'h03, 8'h5A});
    frame3(8'h24, 8'h03, 8'h5A);
    checks++;
    if (exp_wr.size() != 0 || mem[3] !== 8'h5A) begin
      failures++;
      $display("FAIL write_single pending=%0d mem3=%h want 0/5a", exp_wr.size(), mem[3]);
    end
    checks++;
    if (address !== 8'h04) begin
      failures++;
      $display("FAIL write_autoinc addr=%h want 04", address);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx, em;
    exp_rd.push_back(8'h07);
    exp_rd.push_back(8'h08);
    exp_rd.push_back(8'h09);
    exp_miso.push_back(8'hC3);
    exp_miso.push_back(8'h5E);
    spi_start();
    spi_xfer(8'h25, 8, rx);
    spi_xfer(8'h07, 8, rx);
    tick(1);
    checks++;
    if (MISO_OE !== 1'b1) begin
      failures++;
      $display("FAIL read_oe oe=%b want 1", MISO_OE);
    end
    for (int b = 0; b < 2; b++) begin
      spi_xfer(8'h00, 8, rx);
      em = exp_miso.pop_front();
      checks++;
      if (rx !== em) begin
        failures++;
        $display("FAIL read_miso byte%0d got %h want %h", b, rx, em);
      end
    end
    spi_stop();
    checks++;
    if (exp_rd.size() != 0 || MISO_OE !== 1'b0 || address !== 8'h09) begin
      failures++;
      $display("FAIL read_end pending=%0d oe=%b addr=%h want 0/0/09",
               exp_rd.size(), MISO_OE, address);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    exp_wr.push_back({8'hFE, 8'h11});
    exp_wr.push_back({8'hFF, 8'h22});
    exp_wr.push_back({8'h00, 8'h33});
    spi_start();
    spi_xfer(8'h24, 8, rx);
    spi_xfer(8'hFE, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    spi_xfer(8'h33, 8, rx);
    spi_stop();
    checks++;
    if (exp_wr.size() != 0 || mem[254] !== 8'h11 || mem[255] !== 8'h22 ||
        mem[0] !== 8'h33) begin
      failures++;
      $display("FAIL burst_wrap pending=%0d fe=%h ff=%h 00=%h want 0/11/22/33",
               exp_wr.size(), mem[254], mem[255], mem[0]);
    end
    checks++;
    if (address !== 8'h01) begin
      failures++;
      $display("FAIL burst_addr addr=%h want 01", address);
    end
  endtask

  task automatic test_skip();
    skip_viol = 0;
    watch_skip = 1'b1;
    frame3(8'h26, 8'h11, 8'h22);
    watch_skip = 1'b0;
    checks++;
    if (skip_viol != 0) begin
      failures++;
      $display("FAIL skip_oe cycles_enabled=%0d want 0", skip_viol);
    end
    checks++;
    if (address !== 8'h01 || data_in !== 8'h33) begin
      failures++;
      $display("FAIL skip_regs addr=%h data=%h want 01/33", address, data_in);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    spi_start();
    spi_xfer(8'h24, 8, rx);
    spi_xfer(8'h40, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    spi_stop();
    checks++;
    if (address !== 8'h40 || data_in !== 8'h33) begin
      failures++;
      $display("FAIL abort_regs addr=%h data=%h want 40/33", address, data_in);
    end
    exp_wr.push_back({8'h01, 8'hAA});
    frame3(8'h24, 8'h01, 8'hAA);
    checks++;
    if (exp_wr.size() != 0 || mem[1] !== 8'hAA) begin
      failures++;
      $display("FAIL abort_next pending=%0d mem1=%h want 0/aa", exp_wr.size(), mem[1]);
    end
  endtask

  task automatic test_reset_midread();
    logic [7:0] rx;
    exp_rd.push_back(8'h07);
    spi_start();
    spi_xfer(8'h25, 8, rx);
    spi_xfer(8'h07, 8, rx);
    spi_xfer(8'h00, 3, rx);
    checks++;
    if (MISO_OE !== 1'b1 || address !== 8'h07) begin
      failures++;
      $display("FAIL midread_pre oe=%b addr=%h want 1/07", MISO_OE, address);
    end
    @(posedge clk);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (MISO_OE !== 1'b0 || MISO !== 1'b0 || address !== 8'h00 ||
        data_in !== 8'h00) begin
      failures++;
      $display("FAIL midread_rst oe=%b miso=%b addr=%h data=%h want 0/0/00/00",
               MISO_OE, MISO, address, data_in);
    end
    tick(5);
    RST_N = 1'b1;
    tick(10);
    spi_xfer(8'h24, 8, rx);
    spi_xfer(8'h05, 8, rx);
    spi_xfer(8'h77, 8, rx);
    CS_N = 1'b1;
    tick(16);
    checks++;
    if (mem[5] !== 8'h5F || address !== 8'h00 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL midread_nofresh mem5=%h addr=%h pend=%0d want 5f/00/0",
               mem[5], address, exp_rd.size());
    end
    exp_wr.push_back({8'h05, 8'h77});
    frame3(8'h24, 8'h05, 8'h77);
    checks++;
    if (mem[5] !== 8'h77 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL midread_fresh mem5=%h pend=%0d want 77/0", mem[5], exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_skip();
    test_abort();
    test_reset_midread();
    tick(20);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL final_queues wr=%0d rd=%0d want 0/0", exp_wr.size(), exp_rd.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
